// File: rtl/sseg_scan_driver.sv
// Multi-digit time-multiplexed seven-segment scan driver.
// Optional per-digit blinking when SSEG_BLINK_EN is defined.
module sseg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       bcd_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
`ifdef SSEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]         blink,
`endif
  input  logic                          lz_blank,
  output logic [6:0]                    sseg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);

  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   dps_q, dps_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [6:0]              sseg_q, sseg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [IW-1:0]           didx_q, didx_d;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    slot_end;
  logic                    frame_end;

`ifdef SSEG_BLINK_EN
  logic [NUM_DIGITS-1:0] blk_q, blk_d;
  logic [4:0]            fcnt_q, fcnt_d;
  logic                  phase_q, phase_d;
`endif

  // Shadow capture and slot/scan sequencing
  always_comb begin
    bcd_d     = load ? bcd_in : bcd_q;
    dps_d     = load ? dp_in : dps_q;
    slot_end  = (cnt_q == CW'(REFRESH_DIV - 1));
    frame_end = slot_end && (idx_q == IW'(NUM_DIGITS - 1));
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end)
      idx_d = frame_end ? '0 : idx_q + 1'b1;
  end

`ifdef SSEG_BLINK_EN
  // Blink phase flips after every 32 complete frames
  always_comb begin
    blk_d   = load ? blink : blk_q;
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (frame_end) begin
      fcnt_d = fcnt_q + 1'b1;
      if (fcnt_q == 5'd31)
        phase_d = ~phase_q;
    end
  end
`endif

  // Digits that sit in an unbroken run of zeros from the top
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero   = all_zero & (bcd_q[4*i +: 4] == 4'd0);
      lz_mask[i] = all_zero;
    end
  end

  // Decode the active digit and apply blanking and polarity
  always_comb begin
    logic [3:0] cur;
    logic [6:0] seg;
    logic       dpr;
    logic       blank;
    cur   = bcd_q[4*idx_q +: 4];
    dpr   = dps_q[idx_q];
    blank = lz_blank && (idx_q != '0) && lz_mask[idx_q];
    unique case (cur)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000001;
    endcase
    if (blank)
      seg = '0;
`ifdef SSEG_BLINK_EN
    if (phase_q && blk_q[idx_q]) begin
      seg = '0;
      dpr = 1'b0;
    end
`endif
    sseg_d = ACTIVE_LOW ? ~seg : seg;
    dp_d   = ACTIVE_LOW ? ~dpr : dpr;
    an_d   = NUM_DIGITS'(1) << idx_q;
    if (ACTIVE_LOW)
      an_d = ~an_d;
    didx_d = idx_q;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q  <= '0;
      dps_q  <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      sseg_q <= {7{ACTIVE_LOW}};
      dp_q   <= ACTIVE_LOW;
      an_q   <= {NUM_DIGITS{ACTIVE_LOW}};
      didx_q <= '0;
`ifdef SSEG_BLINK_EN
      blk_q   <= '0;
      fcnt_q  <= '0;
      phase_q <= 1'b0;
`endif
    end else begin
      bcd_q  <= bcd_d;
      dps_q  <= dps_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      sseg_q <= sseg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      didx_q <= didx_d;
`ifdef SSEG_BLINK_EN
      blk_q   <= blk_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
`endif
    end
  end

  assign sseg      = sseg_q;
  assign dp        = dp_q;
  assign an        = an_q;
  assign digit_idx = didx_q;

endmodule
